rtype_fetch_ctrl: RTL and testbench

Instruction fetch and issue stage sitting directly upstream of the R-type datapath. Holds a small synchronous instruction memory and a 64-bit PC, fetches one 32-bit word at a time, and decodes the opcode into the datapath's ALUOp and reg_write controls. Each instruction is presented to the datapath under a valid/ready handshake. Fetching stops on an all-zero halt word.

---
 rtl/rtype_pkg.sv | 49 ++++
 rtl/rtype_imem.sv | 33 +++
 rtl/rtype_fetch_ctrl.sv | 133 +++++++++++++
 tb/tb_rtype_fetch_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rtype_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rtype_pkg                                                            |
// | Opcodes, ALUOp encodings, FSM states and decode helper for the      |
// | R-type fetch/issue stage.                                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rtype_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  typedef struct packed {
    logic       legal;
    logic [1:0] alu_op;
    logic       reg_write;
  } ctrl_t;

  // Unknown opcodes come back as a NOP with legal cleared.
  function automatic ctrl_t decode_op(input logic [6:0] op);
    ctrl_t c;
    c.legal     = 1'b1;
    c.alu_op    = ALUOP_MEM;
    c.reg_write = 1'b0;
    case (op)
      OP_RTYPE: begin c.alu_op = ALUOP_R;   c.reg_write = 1'b1; end
      OP_LD:    begin c.alu_op = ALUOP_MEM; c.reg_write = 1'b1; end
      OP_SD:    begin c.alu_op = ALUOP_MEM; c.reg_write = 1'b0; end
      OP_BEQ:   begin c.alu_op = ALUOP_BR;  c.reg_write = 1'b0; end
      default:  c.legal = 1'b0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtype_imem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rtype_imem                                                           |
// | 32-bit instruction memory, one synchronous write and one registered |
// | read port; a same-address write is forwarded to the read data.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rtype_imem #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Write-first so a load in the same cycle as start is seen by the first fetch.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
    if (we && (waddr == raddr)) r_rdata <= wdata;
    else                        r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/rtype_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rtype_fetch_ctrl                                                     |
// | Fetch/issue stage: PC, FSM and opcode decode feeding the R-type     |
// | datapath under valid/ready. Option macro: ILLEGAL_TRAP_EN.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rtype_fetch_ctrl
  import rtype_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter int PC_W       = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  input  logic                          ready,
  output logic [31:0]                   instr,
  output logic [1:0]                    alu_op,
  output logic                          reg_write,
  output logic                          instr_valid,
  output logic [PC_W-1:0]               pc,
  output logic                          halted,
  output logic                          illegal
);

  localparam int AW = $clog2(IMEM_DEPTH);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_FETCH = ST_FETCH;
  localparam logic [1:0] S_ISSUE = ST_ISSUE;
  localparam logic [1:0] S_HALT  = ST_HALT;

  logic [1:0]      r_state, w_state_d;
  logic [PC_W-1:0] r_pc, w_pc_d;
  logic [31:0]     r_instr;
  logic [1:0]      r_alu_op;
  logic            r_reg_write, r_halted, r_illegal;
  logic [31:0]     w_rdata;
  logic            w_idle_like, w_load_we, w_halt_word, w_trap, w_stop;
  logic [1:0]      w_alu_op;
  logic            w_reg_write;
  ctrl_t           w_ctrl;

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_HALT);
  assign w_load_we   = imem_we && w_idle_like;

  // Read address follows the next PC so the word is ready during FETCH.
  rtype_imem #(
    .DEPTH (IMEM_DEPTH),
    .AW    (AW)
  ) u_imem (
    .clk   (clk),
    .we    (w_load_we),
    .waddr (imem_waddr),
    .wdata (imem_wdata),
    .raddr (w_pc_d[AW+1:2]),
    .rdata (w_rdata)
  );

  assign w_ctrl      = decode_op(w_rdata[6:0]);
  assign w_halt_word = (w_rdata == 32'h0000_0000);
  assign w_alu_op    = w_ctrl.legal ? w_ctrl.alu_op : ALUOP_MEM;
  assign w_reg_write = w_ctrl.legal && w_ctrl.reg_write;

`ifdef ILLEGAL_TRAP_EN
  assign w_trap = !w_halt_word && !w_ctrl.legal;
`else
  assign w_trap = 1'b0;
`endif

  assign w_stop = w_halt_word || w_trap;

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (start) begin
          w_state_d = S_FETCH;
          w_pc_d    = '0;
        end
      end
      S_FETCH: w_state_d = w_stop ? S_HALT : S_ISSUE;
      S_ISSUE: begin
        if (ready) begin
          w_state_d = S_FETCH;
          w_pc_d    = r_pc + PC_W'(4);
        end
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_instr     <= '0;
      r_alu_op    <= ALUOP_MEM;
      r_reg_write <= 1'b0;
      r_halted    <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      if (w_idle_like && start) begin
        r_halted  <= 1'b0;
        r_illegal <= 1'b0;
      end
      if (r_state == S_FETCH) begin
        r_instr     <= w_rdata;
        r_alu_op    <= w_trap ? ALUOP_MEM : w_alu_op;
        r_reg_write <= !w_trap && w_reg_write;
        if (w_stop) r_halted  <= 1'b1;
        if (w_trap) r_illegal <= 1'b1;
      end
    end
  end

  assign instr       = r_instr;
  assign alu_op      = r_alu_op;
  assign reg_write   = r_reg_write;
  assign instr_valid = (r_state == S_ISSUE);
  assign pc          = r_pc;
  assign halted      = r_halted;
  assign illegal     = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_rtype_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rtype_fetch_ctrl                                                  |
// | Directed bench: a 64-word and a 4-word instance of the fetch stage. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rtype_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, imem_we, ready;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata, instr;
  logic [1:0]  alu_op;
  logic        reg_write, instr_valid, halted, illegal;
  logic [63:0] pc;

  logic        start4, imem_we4, ready4;
  logic [1:0]  imem_waddr4;
  logic [31:0] imem_wdata4, instr4;
  logic [1:0]  alu_op4;
  logic        reg_write4, instr_valid4, halted4, illegal4;
  logic [63:0] pc4;

  int checks = 0;
  int errors = 0;

  rtype_fetch_ctrl #(.IMEM_DEPTH(64), .PC_W(64)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .ready(ready),
    .instr(instr), .alu_op(alu_op), .reg_write(reg_write),
    .instr_valid(instr_valid), .pc(pc), .halted(halted), .illegal(illegal)
  );

  rtype_fetch_ctrl #(.IMEM_DEPTH(4), .PC_W(64)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .imem_we(imem_we4),
    .imem_waddr(imem_waddr4), .imem_wdata(imem_wdata4), .ready(ready4),
    .instr(instr4), .alu_op(alu_op4), .reg_write(reg_write4),
    .instr_valid(instr_valid4), .pc(pc4), .halted(halted4), .illegal(illegal4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [5:0] a, input logic [31:0] d);
    imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
    tick();
    imem_we = 1'b0;
  endtask

  task automatic load4(input logic [1:0] a, input logic [31:0] d);
    imem_we4 = 1'b1; imem_waddr4 = a; imem_wdata4 = d;
    tick();
    imem_we4 = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (!instr_valid && n < 12) begin tick(); n++; end
    ok = instr_valid;
  endtask

  task automatic wait_halted(output bit ok);
    int n = 0;
    while (!halted && n < 12) begin tick(); n++; end
    ok = halted;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", instr); end
    checks++; if ({alu_op, reg_write} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b want 000", {alu_op, reg_write}); end
    checks++; if ({instr_valid, halted, illegal} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {instr_valid, halted, illegal}); end
    checks++; if (pc !== 64'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc); end
    checks++; if ({instr_valid4, halted4, pc4} !== 66'h0) begin errors++; $display("FAIL reset_dut4 got %h want 0", {instr_valid4, halted4, pc4}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_rtype_single();
    bit seen;
    load(6'd0, 32'h001101B3);
    load(6'd1, 32'h00000000);
    ready = 1'b1;
    pulse_start();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL single_fetch_valid got %b want 0", instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL single_latency_valid got %b want 1", instr_valid); end
    checks++; if (instr !== 32'h001101B3) begin errors++; $display("FAIL single_instr got %h want 001101b3", instr); end
    checks++; if ({alu_op, reg_write} !== 3'b101) begin errors++; $display("FAIL single_ctrl got %b want 101", {alu_op, reg_write}); end
    checks++; if (pc !== 64'd0) begin errors++; $display("FAIL single_pc got %0d want 0", pc); end
    tick(); tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL single_halted got %b want 1", halted); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (instr_valid) seen = 1'b1;
      tick();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL single_no_valid_after_halt got %b want 0", seen); end
  endtask

  task automatic test_ld_sd_beq();
    logic [2:0]  exp_ctrl [3];
    logic [63:0] exp_pc   [3];
    bit ok;
    exp_ctrl[0] = 3'b001; exp_ctrl[1] = 3'b000; exp_ctrl[2] = 3'b010;
    exp_pc[0] = 64'd0;    exp_pc[1] = 64'd4;    exp_pc[2] = 64'd8;
    load(6'd0, 32'h00013183);
    load(6'd1, 32'h00313023);
    load(6'd2, 32'h00208463);
    load(6'd3, 32'h00000000);
    ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      wait_valid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL seq_valid_timeout[%0d] got 0 want 1", i); end
      checks++; if ({alu_op, reg_write} !== exp_ctrl[i]) begin errors++; $display("FAIL seq_ctrl[%0d] got %b want %b", i, {alu_op, reg_write}, exp_ctrl[i]); end
      checks++; if (pc !== exp_pc[i]) begin errors++; $display("FAIL seq_pc[%0d] got %0d want %0d", i, pc, exp_pc[i]); end
      tick();
    end
    wait_halted(ok);
    checks++; if (!ok) begin errors++; $display("FAIL seq_halted got 0 want 1"); end
  endtask

  task automatic test_stall();
    bit ok, stable;
    load(6'd0, 32'h002081B3);
    load(6'd1, 32'h001101B3);
    load(6'd2, 32'h00000000);
    ready = 1'b0;
    pulse_start();
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_valid_timeout got 0 want 1"); end
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (instr !== 32'h002081B3 || alu_op !== 2'b10 || reg_write !== 1'b1
          || pc !== 64'd0 || instr_valid !== 1'b1) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL stall_hold got %b want 1 (instr %h pc %0d valid %b)", stable, instr, pc, instr_valid); end
    ready = 1'b1;
    tick();
    checks++; if (pc !== 64'd4) begin errors++; $display("FAIL stall_pc_advance got %0d want 4", pc); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stall_refetch_valid got %b want 0", instr_valid); end
    tick();
    checks++; if (instr !== 32'h001101B3 || pc !== 64'd4) begin errors++; $display("FAIL stall_next got %h/%0d want 001101b3/4", instr, pc); end
    wait_halted(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_halted got 0 want 1"); end
  endtask

  task automatic test_wrap();
    logic [31:0] words [4];
    int          issued;
    logic [31:0] last_instr;
    logic [63:0] last_pc;
    words[0] = 32'h00000033; words[1] = 32'h000000B3;
    words[2] = 32'h00000133; words[3] = 32'h000001B3;
    for (int i = 0; i < 4; i++) load4(2'(i), words[i]);
    ready4 = 1'b1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    issued = 0;
    last_instr = '0;
    last_pc = '0;
    for (int n = 0; n < 30 && issued < 5; n++) begin
      if (instr_valid4) begin
        issued++;
        last_instr = instr4;
        last_pc    = pc4;
      end
      tick();
    end
    checks++; if (issued !== 5) begin errors++; $display("FAIL wrap_issue_count got %0d want 5", issued); end
    checks++; if (last_instr !== 32'h00000033) begin errors++; $display("FAIL wrap_instr got %h want 00000033", last_instr); end
    checks++; if (last_pc !== 64'd16) begin errors++; $display("FAIL wrap_pc got %0d want 16", last_pc); end
    ready4 = 1'b0;
  endtask

  task automatic test_illegal();
    bit ok;
    load(6'd0, 32'h0000007F);
    load(6'd1, 32'h00000000);
    ready = 1'b1;
    pulse_start();
    tick();
`ifdef ILLEGAL_TRAP_EN
    checks++; if ({halted, illegal, instr_valid} !== 3'b110) begin errors++; $display("FAIL illegal_trap got %b want 110", {halted, illegal, instr_valid}); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL illegal_no_issue got %b want 0", instr_valid); end
`else
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h0000007F) begin errors++; $display("FAIL illegal_nop_issue got %b/%h want 1/0000007f", instr_valid, instr); end
    checks++; if ({alu_op, reg_write, illegal} !== 4'b0000) begin errors++; $display("FAIL illegal_nop_ctrl got %b want 0000", {alu_op, reg_write, illegal}); end
    wait_halted(ok);
    checks++; if (!ok || illegal !== 1'b0) begin errors++; $display("FAIL illegal_nop_halt got %b/%b want 1/0", ok, illegal); end
`endif
  endtask

  task automatic test_reset_mid_issue();
    bit ok, seen;
    load(6'd0, 32'h002081B3);
    load(6'd1, 32'h00000000);
    ready = 1'b0;
    pulse_start();
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_valid_timeout got 0 want 1"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({instr, alu_op, reg_write, instr_valid, pc, halted, illegal} !== 102'h0) begin
      errors++; $display("FAIL rstmid_async got instr %h pc %0d valid %b want all 0", instr, pc, instr_valid);
    end
    tick(); tick();
    rst_n = 1'b1;
    ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (instr_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_valid got %b want 0", seen); end
    load(6'd0, 32'h002081B3);
    pulse_start();
    tick();
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h002081B3) begin errors++; $display("FAIL rstmid_restart got %b/%h want 1/002081b3", instr_valid, instr); end
  endtask

  initial begin
    start = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0; ready = 1'b0;
    start4 = 1'b0; imem_we4 = 1'b0; imem_waddr4 = '0; imem_wdata4 = '0; ready4 = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_rtype_single();
    test_ld_sd_beq();
    test_stall();
    test_wrap();
    test_illegal();
    test_reset_mid_issue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
